// File: rtl/seq_gate_pkg.sv
// Shared types, widths and the elaboration-time pattern fallback function for seq_gate_ctrl.
package seq_gate_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FPULSE = 3'd1,
        MATCH  = 3'd2,
        GWAIT  = 3'd3,
        PASS   = 3'd4,
        FAIL   = 3'd5
    } state_t;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned PAT_MAX = 16;

    // Width of a match index able to hold 0..len.
    function automatic int unsigned idx_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

    // Next match index after receiving bit b with idx bits already matched. Returns the longest
    // prefix of the pattern that is a suffix of (matched bits, b); this covers both the advance
    // (idx+1) and the overlap fallback. Pattern bit 0 received is pat[len-1].
    function automatic int unsigned kmp_next(input logic [PAT_MAX-1:0] pat,
                                             input int unsigned len,
                                             input int unsigned idx,
                                             input logic b);
        int unsigned best;
        int unsigned s;
        logic ok;
        logic sb;
        best = 0;
        for (int unsigned k = 1; k <= PAT_MAX; k++) begin
            if (k <= idx + 1 && k <= len) begin
                ok = 1'b1;
                for (int unsigned j = 0; j < k; j++) begin
                    s  = idx + 1 - k + j;
                    sb = (s == idx) ? b : pat[len - 1 - s];
                    if (sb != pat[len - 1 - j]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_gate_ctrl_if.sv
// Sensor/actuator signal bundle of seq_gate_ctrl.
// Optional rearm input is present when SEQ_GATE_CTRL_REARM_EN is defined.
interface seq_gate_ctrl_if;

    logic x;
    logic y;
`ifdef SEQ_GATE_CTRL_REARM_EN
    logic rearm;
`endif
    logic f;
    logic g;
    logic done;
    logic pass;

    modport master (
        output x,
        output y,
`ifdef SEQ_GATE_CTRL_REARM_EN
        output rearm,
`endif
        input  f,
        input  g,
        input  done,
        input  pass
    );

    modport slave (
        input  x,
        input  y,
`ifdef SEQ_GATE_CTRL_REARM_EN
        input  rearm,
`endif
        output f,
        output g,
        output done,
        output pass
    );

endinterface

// File: rtl/seq_pat_match.sv
// Overlapping serial pattern matcher: match index register plus a constant fallback table.
module seq_pat_match
    import seq_gate_pkg::*;
#(
    parameter int unsigned          PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0]   PAT     = 3'b101
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    input  logic x,
    output logic hit
);

    localparam int unsigned        IDX_W   = idx_width(PAT_LEN);
    localparam logic [PAT_MAX-1:0] PAT_EXT = PAT_MAX'(PAT);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] nxt;
    logic [IDX_W-1:0] nxt_tbl [2**IDX_W][2];

    // Table fully sized to the index width so unreachable codes fall back to 0.
    for (genvar i = 0; i < 2**IDX_W; i++) begin : g_idx
        for (genvar b = 0; b < 2; b++) begin : g_bit
            if (i < PAT_LEN) begin : g_live
                localparam int unsigned NXT = kmp_next(PAT_EXT, PAT_LEN, i, 1'(b));
                assign nxt_tbl[i][b] = IDX_W'(NXT);
            end else begin : g_dead
                assign nxt_tbl[i][b] = '0;
            end
        end
    end

    // Next index lookup and hit detection.
    always_comb begin
        nxt   = nxt_tbl[idx_q][x];
        hit   = en && (nxt == IDX_W'(PAT_LEN));
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (en) begin
            idx_d = hit ? '0 : nxt;
        end
    end

    // Match index register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) idx_q <= '0;
        else         idx_q <= idx_d;
    end

endmodule

// File: rtl/seq_gate_ctrl.sv
// Start-up/gating controller: f pulse, serial pattern search, then a y-acknowledge window on g.
// Define SEQ_GATE_CTRL_REARM_EN to add the rearm input (PASS/FAIL -> MATCH).
module seq_gate_ctrl
    import seq_gate_pkg::*;
#(
    parameter int unsigned          PAT_LEN  = 3,
    parameter logic [PAT_LEN-1:0]   PAT      = 3'b101,
    parameter int unsigned          Y_WIN    = 2,
    parameter int unsigned          F_CYCLES = 1
) (
    input  logic           clk,
    input  logic           resetn,
    seq_gate_ctrl_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] fcnt_q;
    logic [CNT_W-1:0] fcnt_d;
    logic [CNT_W-1:0] wcnt_q;
    logic [CNT_W-1:0] wcnt_d;
    logic             hit;
    logic             rearm_req;

`ifdef SEQ_GATE_CTRL_REARM_EN
    assign rearm_req = bus.rearm;
`else
    assign rearm_req = 1'b0;
`endif

    // Index is held at 0 outside MATCH so every entry into MATCH starts a fresh search.
    seq_pat_match #(
        .PAT_LEN (PAT_LEN),
        .PAT     (PAT)
    ) u_match (
        .clk    (clk),
        .resetn (resetn),
        .en     (state_q == MATCH),
        .clr    (state_q != MATCH),
        .x      (bus.x),
        .hit    (hit)
    );

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                state_d = FPULSE;
                fcnt_d  = '0;
            end
            FPULSE: begin
                if (fcnt_q == CNT_W'(F_CYCLES - 1)) begin
                    state_d = MATCH;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + CNT_W'(1);
                end
            end
            MATCH: begin
                if (hit) begin
                    state_d = GWAIT;
                    wcnt_d  = CNT_W'(1);
                end
            end
            GWAIT: begin
                if (bus.y) begin
                    state_d = PASS;
                end else if (wcnt_q == CNT_W'(Y_WIN)) begin
                    state_d = FAIL;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            PASS, FAIL: begin
                if (rearm_req) state_d = MATCH;
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = '0;
                wcnt_d  = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Moore output decode.
    always_comb begin
        bus.f    = (state_q == FPULSE);
        bus.g    = (state_q == GWAIT) || (state_q == PASS);
        bus.done = (state_q == PASS) || (state_q == FAIL);
        bus.pass = (state_q == PASS);
    end

endmodule

// File: tb/tb_seq_gate_ctrl.sv
// Self-checking bench for seq_gate_ctrl: a default instance and a 4-bit-pattern instance, each
// checked cycle by cycle against a timeline computed from the stimulus.
module tb_seq_gate_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;

    seq_gate_ctrl_if bus0 ();
    seq_gate_ctrl_if bus1 ();

    seq_gate_ctrl #(
        .PAT_LEN  (3),
        .PAT      (3'b101),
        .Y_WIN    (2),
        .F_CYCLES (1)
    ) u_dut0 (
        .clk    (clk),
        .resetn (rst0),
        .bus    (bus0.slave)
    );

    seq_gate_ctrl #(
        .PAT_LEN  (4),
        .PAT      (4'b1011),
        .Y_WIN    (3),
        .F_CYCLES (2)
    ) u_dut1 (
        .clk    (clk),
        .resetn (rst1),
        .bus    (bus1.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    localparam int MAXC = 64;
    bit xs [MAXC];
    bit ys [MAXC];
    bit ef [MAXC];
    bit eg [MAXC];
    bit ed [MAXC];
    bit ep [MAXC];

    // Expected outputs per cycle; cycle 0 is the first cycle after reset release.
    task automatic build_expect(input int n, input int plen, input logic [15:0] pat,
                                input int fcyc, input int ywin);
        bit hist[$];
        int k;
        int jy;
        bit ok;
        bit gwin;
        bit inpass;
        bit infail;
        k  = -1;
        jy = -1;
        for (int c = fcyc + 1; c < n && k < 0; c++) begin
            hist.push_back(xs[c]);
            if (hist.size() >= plen) begin
                ok = 1'b1;
                for (int j = 0; j < plen; j++)
                    if (hist[hist.size() - plen + j] != pat[plen - 1 - j]) ok = 1'b0;
                if (ok) k = c;
            end
        end
        if (k >= 0)
            for (int c = k + 1; c <= k + ywin && c < n; c++)
                if (ys[c] && jy < 0) jy = c;
        for (int c = 0; c < n; c++) begin
            gwin   = (k >= 0) && (c > k) && (c <= k + ywin) && (jy < 0 || c <= jy);
            inpass = (jy >= 0) && (c > jy);
            infail = (k >= 0) && (jy < 0) && (c > k + ywin);
            ef[c]  = (c >= 1) && (c <= fcyc);
            eg[c]  = gwin || inpass;
            ed[c]  = inpass || infail;
            ep[c]  = inpass;
        end
    endtask

    task automatic drive(input int inst, input bit xv, input bit yv);
        if (inst == 0) begin
            bus0.x = xv;
            bus0.y = yv;
        end else begin
            bus1.x = xv;
            bus1.y = yv;
        end
    endtask

    function automatic logic [3:0] outs(input int inst);
        if (inst == 0) return {bus0.f, bus0.g, bus0.done, bus0.pass};
        return {bus1.f, bus1.g, bus1.done, bus1.pass};
    endfunction

    task automatic set_rst(input int inst, input logic v);
        if (inst == 0) rst0 = v;
        else           rst1 = v;
    endtask

    // Reset the instance, release it, then play xs/ys and compare every cycle.
    task automatic run_case(input int inst, input int n, input int plen, input logic [15:0] pat,
                            input int fcyc, input int ywin, input string name);
        logic [3:0] exp;
        logic [3:0] got;
        build_expect(n, plen, pat, fcyc, ywin);
        drive(inst, 1'b0, 1'b0);
        set_rst(inst, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        set_rst(inst, 1'b1);
        for (int c = 0; c < n; c++) begin
            drive(inst, xs[c], ys[c]);
            @(negedge clk);
            exp = {ef[c], eg[c], ed[c], ep[c]};
            got = outs(inst);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d {f,g,done,pass} got %b expected %b",
                         name, c, got, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            xs[c] = 1'b0;
            ys[c] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        n_checks++;
        if (outs(0) !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_dut0 got %b expected 0000", outs(0));
        end
        n_checks++;
        if (outs(1) !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_dut1 got %b expected 0000", outs(1));
        end
    endtask

    task automatic test_basic();
        clear_stim();
        xs[2] = 1; xs[3] = 0; xs[4] = 1;
        run_case(0, 10, 3, 16'b101, 1, 2, "basic_101");
    endtask

    task automatic test_overlap();
        clear_stim();
        xs[2] = 1; xs[3] = 1; xs[4] = 0; xs[5] = 1;
        run_case(0, 10, 3, 16'b101, 1, 2, "overlap_1101");
        clear_stim();
        xs[2] = 1; xs[3] = 0; xs[4] = 0; xs[5] = 1; xs[6] = 0; xs[7] = 1;
        run_case(0, 12, 3, 16'b101, 1, 2, "fallback_100101");
    endtask

    task automatic test_pass_fail();
        clear_stim();
        xs[2] = 1; xs[3] = 0; xs[4] = 1;
        ys[5] = 0; ys[6] = 1;
        run_case(0, 32, 3, 16'b101, 1, 2, "pass_hold");
        clear_stim();
        xs[2] = 1; xs[3] = 0; xs[4] = 1;
        for (int c = 8; c < 16; c++) ys[c] = 1;  // late y must not rescue the window
        run_case(0, 16, 3, 16'b101, 1, 2, "fail_latch");
    endtask

    task automatic test_alt_config();
        clear_stim();
        xs[3] = 1; xs[4] = 0; xs[5] = 1; xs[6] = 0; xs[7] = 1; xs[8] = 1;
        ys[11] = 1;
        run_case(1, 20, 4, 16'b1011, 2, 3, "alt_1011");
    endtask

    task automatic test_async_reset();
        clear_stim();
        xs[2] = 1; xs[3] = 0; xs[4] = 1;
        rst0 = 1'b0;
        drive(0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            drive(0, xs[c], 1'b0);
            if (c < 5) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        n_checks++;
        if (bus0.g !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre_g got %b expected 1", bus0.g);
        end
        rst0 = 1'b0;
        #1;
        n_checks++;
        if (outs(0) !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset_immediate got %b expected 0000", outs(0));
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (outs(0) !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset_held got %b expected 0000", outs(0));
        end
        run_case(0, 10, 3, 16'b101, 1, 2, "restart_after_reset");
    endtask

    task automatic test_random();
        int inst;
        for (int it = 0; it < 24; it++) begin
            inst = int'($urandom_range(0, 1));
            for (int c = 0; c < MAXC; c++) begin
                xs[c] = 1'($urandom_range(0, 1));
                ys[c] = ($urandom_range(0, 3) == 0);
            end
            if (inst == 0) run_case(0, 40, 3, 16'b101, 1, 2, "random_dut0");
            else           run_case(1, 40, 4, 16'b1011, 2, 3, "random_dut1");
        end
    endtask

`ifdef SEQ_GATE_CTRL_REARM_EN
    task automatic test_rearm();
        logic [3:0] exp_t [14];
        bit         xv    [14];
        exp_t = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100,
                  4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
        xv    = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0};
        rst0 = 1'b0;
        drive(0, 1'b0, 1'b0);
        bus0.rearm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b1;
        for (int c = 0; c < 14; c++) begin
            drive(0, xv[c], 1'b0);
            bus0.rearm = (c == 8) || (c == 10);
            @(negedge clk);
            n_checks++;
            if (outs(0) !== exp_t[c]) begin
                n_fail++;
                $display("FAIL rearm cycle %0d {f,g,done,pass} got %b expected %b",
                         c, outs(0), exp_t[c]);
            end
            @(posedge clk);
            #1;
        end
        bus0.rearm = 1'b0;
    endtask
`endif

    initial begin
        bus0.x = 1'b0; bus0.y = 1'b0;
        bus1.x = 1'b0; bus1.y = 1'b0;
`ifdef SEQ_GATE_CTRL_REARM_EN
        bus0.rearm = 1'b0;
        bus1.rearm = 1'b0;
`endif
        test_reset();
        test_basic();
        test_overlap();
        test_pass_fail();
        test_alt_config();
        test_async_reset();
        test_random();
`ifdef SEQ_GATE_CTRL_REARM_EN
        test_rearm();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
